// File: rtl/mux_32x1_sync.sv
// Registered 32-to-1 word selector with a fixed one-cycle read latency (MIPS register-file read port).
// Optional load enable: define MUX_32X1_LOAD_EN to add the en port.
module mux_32x1_sync (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Y,
  input  logic [4:0]  S,
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  input  logic [31:0] I4,
  input  logic [31:0] I5,
  input  logic [31:0] I6,
  input  logic [31:0] I7,
  input  logic [31:0] I8,
  input  logic [31:0] I9,
  input  logic [31:0] I10,
  input  logic [31:0] I11,
  input  logic [31:0] I12,
  input  logic [31:0] I13,
  input  logic [31:0] I14,
  input  logic [31:0] I15,
  input  logic [31:0] I16,
  input  logic [31:0] I17,
  input  logic [31:0] I18,
  input  logic [31:0] I19,
  input  logic [31:0] I20,
  input  logic [31:0] I21,
  input  logic [31:0] I22,
  input  logic [31:0] I23,
  input  logic [31:0] I24,
  input  logic [31:0] I25,
  input  logic [31:0] I26,
  input  logic [31:0] I27,
  input  logic [31:0] I28,
  input  logic [31:0] I29,
  input  logic [31:0] I30,
  input  logic [31:0] I31
`ifdef MUX_32X1_LOAD_EN
  ,
  input  logic        en
`endif
);

  logic [31:0] next_y;

  // All 32 select codes are decoded, so the case is full and no latch can form.
  always_comb begin
    next_y = I0;
    case (S)
      5'd0:  next_y = I0;
      5'd1:  next_y = I1;
      5'd2:  next_y = I2;
      5'd3:  next_y = I3;
      5'd4:  next_y = I4;
      5'd5:  next_y = I5;
      5'd6:  next_y = I6;
      5'd7:  next_y = I7;
      5'd8:  next_y = I8;
      5'd9:  next_y = I9;
      5'd10: next_y = I10;
      5'd11: next_y = I11;
      5'd12: next_y = I12;
      5'd13: next_y = I13;
      5'd14: next_y = I14;
      5'd15: next_y = I15;
      5'd16: next_y = I16;
      5'd17: next_y = I17;
      5'd18: next_y = I18;
      5'd19: next_y = I19;
      5'd20: next_y = I20;
      5'd21: next_y = I21;
      5'd22: next_y = I22;
      5'd23: next_y = I23;
      5'd24: next_y = I24;
      5'd25: next_y = I25;
      5'd26: next_y = I26;
      5'd27: next_y = I27;
      5'd28: next_y = I28;
      5'd29: next_y = I29;
      5'd30: next_y = I30;
      5'd31: next_y = I31;
      default: next_y = I0;
    endcase
  end

  // Reset wins over the load path, including when en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      Y <= 32'h0000_0000;
    end else begin
`ifdef MUX_32X1_LOAD_EN
      if (en) begin
        Y <= next_y;
      end
`else
      Y <= next_y;
`endif
    end
  end

endmodule

// File: tb/tb_mux_32x1_sync.sv
// Self-checking bench for mux_32x1_sync: directed scenarios plus randomized traffic
// checked against a word-array reference model through an expected-value queue.
module tb_mux_32x1_sync;

  logic        clk;
  logic        reset;
  logic [31:0] Y;
  logic [4:0]  S;
  logic [31:0] din [32];
  logic        en;

  int cmp_count;
  int err_count;
  logic [31:0] exp_q [$];

  mux_32x1_sync dut (
    .clk(clk), .reset(reset), .Y(Y), .S(S),
    .I0(din[0]),   .I1(din[1]),   .I2(din[2]),   .I3(din[3]),
    .I4(din[4]),   .I5(din[5]),   .I6(din[6]),   .I7(din[7]),
    .I8(din[8]),   .I9(din[9]),   .I10(din[10]), .I11(din[11]),
    .I12(din[12]), .I13(din[13]), .I14(din[14]), .I15(din[15]),
    .I16(din[16]), .I17(din[17]), .I18(din[18]), .I19(din[19]),
    .I20(din[20]), .I21(din[21]), .I22(din[22]), .I23(din[23]),
    .I24(din[24]), .I25(din[25]), .I26(din[26]), .I27(din[27]),
    .I28(din[28]), .I29(din[29]), .I30(din[30]), .I31(din[31])
`ifdef MUX_32X1_LOAD_EN
    , .en(en)
`endif
  );

  // Clock and initial drive values
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers: inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic [4:0] sel);
    @(negedge clk);
    reset = rst;
    S     = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic load_index_pattern();
    for (int k = 0; k < 32; k++) din[k] = k;
  endtask

  task automatic test_reset();
    load_index_pattern();
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 5'd5);
      cmp_count++;
      if (Y !== 32'h0) begin
        $display("FAIL reset_hold edge %0d: got %h expected %h", n, Y, 32'h0);
        err_count++;
      end
    end
    drive(1'b0, 5'd5);
    cmp_count++;
    if (Y !== 32'h5) begin
      $display("FAIL reset_release: got %h expected %h", Y, 32'h5);
      err_count++;
    end
  endtask

  task automatic test_sweep();
    load_index_pattern();
    for (int s = 0; s < 32; s++) begin
      drive(1'b0, s[4:0]);
      cmp_count++;
      if (Y !== 32'(s)) begin
        $display("FAIL sweep S=%0d: got %h expected %h", s, Y, 32'(s));
        err_count++;
      end
    end
  endtask

  task automatic test_wrap();
    load_index_pattern();
    drive(1'b0, 5'd31);
    cmp_count++;
    if (Y !== 32'h1F) begin
      $display("FAIL wrap_31: got %h expected %h", Y, 32'h1F);
      err_count++;
    end
    drive(1'b0, 5'd31 + 5'd1);
    cmp_count++;
    if (Y !== 32'h0) begin
      $display("FAIL wrap_0: got %h expected %h", Y, 32'h0);
      err_count++;
    end
  endtask

  task automatic test_bit_isolation();
    logic [31:0] pats [2];
    logic [31:0] want;
    pats[0] = 32'hFFFF_FFFF;
    pats[1] = 32'hA5A5_5A5A;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 32; k++) din[k] = 32'h0;
      din[17] = pats[p];
      for (int s = 0; s < 32; s++) begin
        drive(1'b0, s[4:0]);
        want = (s == 17) ? pats[p] : 32'h0;
        cmp_count++;
        if (Y !== want) begin
          $display("FAIL bit_isolation pat=%h S=%0d: got %h expected %h", pats[p], s, Y, want);
          err_count++;
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    load_index_pattern();
    for (int s = 0; s < 13; s++) begin
      drive(s == 10, s[4:0]);
      cmp_count++;
      if (Y !== ((s == 10) ? 32'h0 : 32'(s))) begin
        $display("FAIL mid_reset S=%0d: got %h expected %h", s, Y,
                 (s == 10) ? 32'h0 : 32'(s));
        err_count++;
      end
    end
  endtask

  task automatic test_glitch();
    load_index_pattern();
    drive(1'b0, 5'd7);
    #2;
    S       = 5'd3;
    din[7]  = 32'hDEAD_BEEF;
    din[3]  = 32'h1234_5678;
    #1;
    cmp_count++;
    if (Y !== 32'h7) begin
      $display("FAIL glitch_hold: got %h expected %h", Y, 32'h7);
      err_count++;
    end
    drive(1'b0, 5'd3);
    cmp_count++;
    if (Y !== 32'h1234_5678) begin
      $display("FAIL glitch_next: got %h expected %h", Y, 32'h1234_5678);
      err_count++;
    end
  endtask

  // Reference model: the register shows whichever array word the sampled select named, or zero under reset.
  task automatic test_random();
    logic [31:0] want;
    logic [4:0]  sel;
    logic        rst;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 32; k++) din[k] = $urandom;
      sel = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 15) == 0);
      exp_q.push_back(rst ? 32'h0 : din[sel]);
      drive(rst, sel);
      want = exp_q.pop_front();
      cmp_count++;
      if (Y !== want) begin
        $display("FAIL random n=%0d S=%0d rst=%0b: got %h expected %h", n, sel, rst, Y, want);
        err_count++;
      end
    end
  endtask

`ifdef MUX_32X1_LOAD_EN
  task automatic test_load_en();
    logic [4:0]  sels [4];
    logic        ens  [4];
    logic [31:0] wants [4];
    load_index_pattern();
    sels[0] = 5'd5; ens[0] = 1'b1; wants[0] = 32'h5;
    sels[1] = 5'd3; ens[1] = 1'b0; wants[1] = 32'h5;
    sels[2] = 5'd9; ens[2] = 1'b0; wants[2] = 32'h5;
    sels[3] = 5'd9; ens[3] = 1'b1; wants[3] = 32'h9;
    for (int n = 0; n < 4; n++) begin
      en = ens[n];
      drive(1'b0, sels[n]);
      cmp_count++;
      if (Y !== wants[n]) begin
        $display("FAIL load_en step %0d: got %h expected %h", n, Y, wants[n]);
        err_count++;
      end
    end
    en = 1'b0;
    drive(1'b1, 5'd9);
    cmp_count++;
    if (Y !== 32'h0) begin
      $display("FAIL load_en_reset: got %h expected %h", Y, 32'h0);
      err_count++;
    end
    en = 1'b1;
  endtask
`endif

  initial begin
    cmp_count = 0;
    err_count = 0;
    reset = 1'b1;
    S     = 5'd0;
    en    = 1'b1;
    for (int k = 0; k < 32; k++) din[k] = 32'h0;

    test_reset();
    test_sweep();
    test_wrap();
    test_bit_isolation();
    test_mid_reset();
    test_glitch();
    test_random();
`ifdef MUX_32X1_LOAD_EN
    test_load_en();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
